vga_map_scan: RTL and testbench

VGA_MAP_SCAN -- requirements
Module: vga_map_scan

---
 rtl/vga_map_scan.sv | 140 ++++++++++++++
 tb/tb_vga_map_scan.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_map_scan.sv
// vga_map_scan: 640x480@60 VGA scan generator with a camera-scrolled map window.
// Define VGA_MAP_FLIP_Y_EN to make map y count upward from the window's bottom row.
module vga_map_scan #(
    parameter int CLK_DIV      = 4,
    parameter int MAP_ORIGIN_X = 270,
    parameter int MAP_ORIGIN_Y = 190,
    parameter int MAP_WIDTH_X  = 100,
    parameter int MAP_WIDTH_Y  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] cam_x,
    input  logic [9:0] cam_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] map_x,
    output logic [9:0] map_y,
    output logic       map_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [10:0] X_LO  = 11'(MAP_ORIGIN_X);
    localparam logic [10:0] X_HI  = 11'(MAP_ORIGIN_X + MAP_WIDTH_X);
    localparam logic [10:0] Y_LO  = 11'(MAP_ORIGIN_Y);
    localparam logic [10:0] Y_HI  = 11'(MAP_ORIGIN_Y + MAP_WIDTH_Y);
    localparam logic [10:0] Y_BOT = 11'(MAP_ORIGIN_Y + MAP_WIDTH_Y - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic [9:0]       cam_x_q, cam_x_d;
    logic [9:0]       cam_y_q, cam_y_d;
    logic             pix_tick;
    logic             frame_end;

    logic             hsync_q, vsync_q, video_on_q, map_on_q, frame_start_q;
    logic [9:0]       map_x_q, map_y_q, pixel_x_q, pixel_y_q;

    logic [10:0]      h_ext, v_ext, mx_sum, my_sum;
    logic             vis_c, in_win_c;
    logic             unused_bits;

    assign pix_tick  = (div_q == DIV_LAST);
    assign frame_end = pix_tick && (h_cnt_q == 10'd799) && (v_cnt_q == 10'd524);

    always_comb begin
        div_d   = pix_tick ? '0 : div_q + 1'b1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        cam_x_d = cam_x_q;
        cam_y_d = cam_y_q;
        if (pix_tick) begin
            if (h_cnt_q == 10'd799) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == 10'd524) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
        // The camera offset is sampled only at the frame boundary so a frame never tears.
        if (frame_end) begin
            cam_x_d = cam_x;
            cam_y_d = cam_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            cam_x_q <= '0;
            cam_y_q <= '0;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            cam_x_q <= cam_x_d;
            cam_y_q <= cam_y_d;
        end
    end

    always_comb begin
        h_ext    = {1'b0, h_cnt_q};
        v_ext    = {1'b0, v_cnt_q};
        vis_c    = (h_cnt_q < 10'd640) && (v_cnt_q < 10'd480);
        in_win_c = vis_c && (h_ext >= X_LO) && (h_ext < X_HI)
                         && (v_ext >= Y_LO) && (v_ext < Y_HI);
        mx_sum   = h_ext - X_LO + {1'b0, cam_x_q};
`ifdef VGA_MAP_FLIP_Y_EN
        my_sum   = Y_BOT - v_ext + {1'b0, cam_y_q};
`else
        my_sum   = v_ext - Y_LO + {1'b0, cam_y_q};
`endif
    end

    assign unused_bits = ^{mx_sum[10], my_sum[10], Y_BOT[0]};

    // Outputs are re-registered every clk from the counters, giving one clk of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            map_on_q      <= 1'b0;
            frame_start_q <= 1'b0;
            map_x_q       <= '0;
            map_y_q       <= '0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
        end else begin
            hsync_q       <= !((h_cnt_q >= 10'd656) && (h_cnt_q <= 10'd751));
            vsync_q       <= !((v_cnt_q >= 10'd490) && (v_cnt_q <= 10'd491));
            video_on_q    <= vis_c;
            map_on_q      <= in_win_c;
            frame_start_q <= frame_end;
            map_x_q       <= in_win_c ? mx_sum[9:0] : 10'd0;
            map_y_q       <= in_win_c ? my_sum[9:0] : 10'd0;
            pixel_x_q     <= h_cnt_q;
            pixel_y_q     <= v_cnt_q;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign map_on      = map_on_q;
    assign frame_start = frame_start_q;
    assign map_x       = map_x_q;
    assign map_y       = map_y_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;

endmodule

// File: tb/tb_vga_map_scan.sv
// Scoreboard bench for vga_map_scan: expected output vectors are queued against an
// edge index since reset release and a monitor compares them when that edge arrives.
`timescale 1ns/1ps
module tb_vga_map_scan;

    localparam int D     = 2;
    localparam int OX    = 270;
    localparam int OY    = 190;
    localparam int WX    = 100;
    localparam int WY    = 100;
    localparam int FRAME = 800 * 525;
    localparam logic [44:0] RESET_VEC = {1'b1, 1'b1, 3'b000, 40'd0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] cam_x = '0;
    logic [9:0] cam_y = '0;
    logic       hsync, vsync, video_on, map_on, frame_start;
    logic [9:0] map_x, map_y, pixel_x, pixel_y;
    logic [44:0] obs;

    vga_map_scan #(.CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .cam_x(cam_x), .cam_y(cam_y),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .map_x(map_x), .map_y(map_y), .map_on(map_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    assign obs = {hsync, vsync, video_on, map_on, frame_start, map_x, map_y, pixel_x, pixel_y};

    typedef struct {
        int          k;
        logic [44:0] exp;
        string       tag;
    } entry_t;

    entry_t sbq[$];
    int     fsK[$];
    int     nextK = 32'h7fffffff;
    int     checks = 0;
    int     passes = 0;
    int     kNow = 0;
    bit     firstRun = 1'b1;
    int     hsLow = 0, vsLow = 0, hsLowRestart = 0;

    always @(posedge clk) begin
        if (rst) kNow <= 0;
        else     kNow <= kNow + 1;
    end

    // Screen-level reference: what a pixel at (h,v) must look like with a given latched camera.
    function automatic logic [44:0] refModel(int h, int v, int cx, int cy, bit fs);
        bit vis, win, hs, vs;
        int mx, my;
        vis = (h < 640) && (v < 480);
        win = vis && (h >= OX) && (h < OX + WX) && (v >= OY) && (v < OY + WY);
        hs  = !((h >= 656) && (h <= 751));
        vs  = !((v >= 490) && (v <= 491));
        mx  = win ? (h - OX + cx) % 1024 : 0;
`ifdef VGA_MAP_FLIP_Y_EN
        my  = win ? (OY + WY - 1 - v + cy) % 1024 : 0;
`else
        my  = win ? (v - OY + cy) % 1024 : 0;
`endif
        return {hs, vs, vis, win, fs, 10'(mx), 10'(my), 10'(h), 10'(v)};
    endfunction

    task automatic checkOutput(string tag, logic [44:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h (hs,vs,vid,map,fs,mx,my,px,py)", tag, obs, exp);
    endtask

    task automatic checkValue(string tag, int got, int exp);
        checks++;
        if (got == exp) passes++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic pushEntry(entry_t e);
        sbq.push_back(e);
        if (e.k < nextK) nextK = e.k;
    endtask

    task automatic pushPixel(int f, int h, int v, int cx, int cy, string tag);
        int     n;
        entry_t e;
        n     = f * FRAME + v * 800 + h;
        e.k   = D * n + 1;
        e.exp = refModel(h, v, cx, cy, 1'b0);
        e.tag = tag;
        pushEntry(e);
        e.k   = D * n + D;
        e.exp = refModel(h, v, cx, cy, ((n + 1) % FRAME) == 0);
        e.tag = {tag, "_hold"};
        pushEntry(e);
    endtask

    task automatic applyStimulus(int f, int cx, int cy, int nMax, int count);
        int n;
        for (int i = 0; i < count; i++) begin
            n = int'($urandom_range(nMax));
            pushPixel(f, n % 800, n / 800, cx, cy, $sformatf("rand_f%0d_%0d_%0d", f, n % 800, n / 800));
        end
    endtask

    task automatic waitUntil(int k);
        while (kNow < k) @(negedge clk);
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst && sbq.size() > 0 && kNow >= nextK) begin
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].k == kNow) begin
                    checkOutput(sbq[i].tag, sbq[i].exp);
                    sbq.delete(i);
                end else if (sbq[i].k < kNow) begin
                    checks++;
                    $display("[TB] FAIL %s: missed at edge %0d (now %0d)", sbq[i].tag, sbq[i].k, kNow);
                    sbq.delete(i);
                end
            end
            nextK = 32'h7fffffff;
            foreach (sbq[i]) if (sbq[i].k < nextK) nextK = sbq[i].k;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (frame_start) fsK.push_back(kNow);
            if (firstRun) begin
                if (kNow >= 1 && kNow <= D * 800 && !hsync) hsLow++;
                if (kNow >= 1 && kNow <= D * FRAME && !vsync) vsLow++;
            end else begin
                if (kNow >= 1 && kNow <= D * 656 && !hsync) hsLowRestart++;
            end
        end
    end

    initial begin
        #(64'd60_000_000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cy1, cy2, nr;
        repeat (3) @(posedge clk);
        #1 checkOutput("reset_state", RESET_VEC);

        // Camera inputs before release must not leak into the first frame.
        cam_x = 10'($urandom);
        cam_y = 10'($urandom);
        cy1   = int'($urandom_range(1023));
        cy2   = int'($urandom_range(1023));

        pushPixel(0, 0,   0,   0, 0, "first_pixel");
        pushPixel(0, 640, 0,   0, 0, "video_off_x");
        pushPixel(0, 269, 190, 0, 0, "win_left_out");
        pushPixel(0, 270, 190, 0, 0, "win_origin");
        pushPixel(0, 369, 289, 0, 0, "win_corner");
        pushPixel(0, 370, 289, 0, 0, "win_right_out");
        pushPixel(0, 639, 479, 0, 0, "video_last");
        pushPixel(0, 799, 524, 0, 0, "frame_last");
        applyStimulus(0, 0, 0, FRAME - 1, 12);
        pushPixel(1, 270, 190, 5, cy1, "cam_latch_next");
        applyStimulus(1, 5, cy1, FRAME - 1, 12);
        pushPixel(2, 280, 200, 1020, cy2, "cam_wrap");
        nr = 2 * FRAME + 300 * 800 + 400;
        applyStimulus(2, 1020, cy2, 300 * 800 + 390, 8);

        @(negedge clk) rst = 1'b0;

        waitUntil(D * (100 * 800));
        cam_x = 10'd5;
        waitUntil(D * (400 * 800));
        cam_y = 10'(cy1);
        waitUntil(D * (FRAME + 300 * 800));
        cam_x = 10'd1020;
        cam_y = 10'(cy2);

        waitUntil(D * nr);
        #1;
        checkValue("queue_drained_run1", sbq.size(), 0);
        checkValue("frame_start_count", fsK.size(), 2);
        if (fsK.size() == 2) begin
            checkValue("first_frame_start_edge", fsK[0], D * FRAME);
            checkValue("frame_start_interval", fsK[1] - fsK[0], D * FRAME);
        end
        checkValue("hsync_low_clks_line", hsLow, 96 * D);
        checkValue("vsync_low_clks_frame", vsLow, 1600 * D);

        firstRun = 1'b0;
        rst = 1'b1;
        #1 checkOutput("mid_reset_immediate", RESET_VEC);
        repeat (3) @(posedge clk);
        #1 checkOutput("mid_reset_hold", RESET_VEC);

        // cam_x is still 1020 on the input; the restarted frame must use a cleared offset.
        pushPixel(0, 0,   0,   0, 0, "restart_origin");
        pushPixel(0, 655, 0,   0, 0, "restart_hs_before");
        pushPixel(0, 656, 0,   0, 0, "restart_hs_start");
        pushPixel(0, 751, 0,   0, 0, "restart_hs_end");
        pushPixel(0, 752, 0,   0, 0, "restart_hs_after");
        pushPixel(0, 280, 200, 0, 0, "restart_cam_cleared");
        applyStimulus(0, 0, 0, 200 * 800 + 280, 6);

        @(negedge clk) rst = 1'b0;
        waitUntil(D * (200 * 800 + 281) + D);
        #1;
        checkValue("queue_drained_run2", sbq.size(), 0);
        checkValue("restart_hsync_high", hsLowRestart, 0);
        checkValue("no_partial_frame_start", fsK.size(), 2);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
